// File: rtl/cbx_param_pkg.sv
// Shared types and elaboration-time helpers for the parametrised connection block.
// CBX_PARAM_CFG_PARITY_EN appends one even-parity bit to the configuration chain.
package cbx_param_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } cfg_state_e;

`ifdef CBX_PARAM_CFG_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

   // Track feeding mux input pair j of pin p.
   function automatic int track_idx(input int p, input int j, input int stride, input int width);
      return (p + j * stride) % width;
   endfunction

   function automatic int chain_len(input int num_ipin, input int mux_size);
      return num_ipin * clog2(mux_size) + PARITY_BITS;
   endfunction

endpackage

// File: rtl/cbx_param_pin_mux.sv
// MUX_SIZE:1 track-select mux for one grid input pin; select codes past the
// last input produce 0.
module cbx_param_pin_mux
   import cbx_param_pkg::*;
#(
   parameter int MUX_SIZE = 10,
   parameter int SEL_W    = clog2(MUX_SIZE)
) (
   input  logic [MUX_SIZE-1:0] mux_in,
   input  logic [SEL_W-1:0]    sel,
   output logic                mux_out
);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      mux_out = 1'b0;
      for (int i = 0; i < MUX_SIZE; i++) begin
         if (sel == SEL_W'(i)) mux_out = mux_in[i];
      end
   end

endmodule

// File: rtl/cbx_param_cfgchain.sv
// Horizontal connection block: track pass-through, per-pin track muxes and a counted
// configuration chain with load FSM. CBX_PARAM_CFG_PARITY_EN enables the parity check.
module cbx_param_cfgchain
   import cbx_param_pkg::*;
#(
   parameter int CHAN_WIDTH   = 20,
   parameter int NUM_IPIN     = 4,
   parameter int MUX_SIZE     = 10,
   parameter int TRACK_STRIDE = 4
) (
   input  logic                  prog_clk,
   input  logic                  prog_reset,
   input  logic                  ccff_en,
   input  logic                  ccff_head,
   input  logic [CHAN_WIDTH-1:0] chanx_left_in,
   input  logic [CHAN_WIDTH-1:0] chanx_right_in,
   output logic [CHAN_WIDTH-1:0] chanx_left_out,
   output logic [CHAN_WIDTH-1:0] chanx_right_out,
   output logic [NUM_IPIN-1:0]   top_grid_pin,
   output logic                  ccff_tail,
   output logic                  cfg_done,
   output logic                  cfg_err
);

   localparam int SEL_W = clog2(MUX_SIZE);
   localparam int L     = chain_len(NUM_IPIN, MUX_SIZE);
   localparam int OFF   = PARITY_BITS;
   localparam int CNT_W = clog2(L + 1);

   logic [L-1:0]      cfg_q, cfg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   cfg_state_e        state_q, state_d;
   logic              en_prev_q, en_prev_d;
   logic [NUM_IPIN-1:0] pin_raw;

   assign chanx_left_out  = chanx_right_in;
   assign chanx_right_out = chanx_left_in;

   always_comb begin
      cfg_d     = ccff_en ? {cfg_q[L-2:0], ccff_head} : cfg_q;
      cnt_d     = cnt_q;
      state_d   = state_q;
      en_prev_d = ccff_en;
      case (state_q)
         IDLE: begin
            if (ccff_en) begin
               cnt_d   = CNT_W'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (ccff_en) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q + CNT_W'(1) == CNT_W'(L)) state_d = DONE;
            end
         end
         DONE: begin
            // A rising ccff_en restarts loading; a continuous high just passes data downstream.
            if (ccff_en && !en_prev_q) begin
               cnt_d   = CNT_W'(1);
               state_d = SHIFT;
            end else if (ccff_en) begin
               cnt_d = CNT_W'(L);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         cfg_q     <= '0;
         cnt_q     <= '0;
         state_q   <= IDLE;
         en_prev_q <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         en_prev_q <= en_prev_d;
      end
   end

   assign ccff_tail = cfg_q[L-1];
   assign cfg_done  = (state_q == DONE);

`ifdef CBX_PARAM_CFG_PARITY_EN
   assign cfg_err = cfg_done & (^cfg_q);
`else
   assign cfg_err = 1'b0;
`endif

   for (genvar p = 0; p < NUM_IPIN; p++) begin : g_pin
      logic [MUX_SIZE-1:0] mux_in;
      for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_pair
         localparam int T = track_idx(p, j, TRACK_STRIDE, CHAN_WIDTH);
         assign mux_in[2*j]   = chanx_left_in[T];
         assign mux_in[2*j+1] = chanx_right_in[T];
      end
      cbx_param_pin_mux #(
         .MUX_SIZE (MUX_SIZE),
         .SEL_W    (SEL_W)
      ) u_pin_mux (
         .mux_in  (mux_in),
         .sel     (cfg_q[OFF + p*SEL_W +: SEL_W]),
         .mux_out (pin_raw[p])
      );
   end

   // Pins stay quiet until a complete, parity-clean configuration is present.
   assign top_grid_pin = (cfg_done && !cfg_err) ? pin_raw : '0;

endmodule

// File: tb/tb_cbx_param_cfgchain.sv
// Self-checking bench for cbx_param_cfgchain: directed table plus random stimulus
// against a queue-based model of the configuration chain.
module tb_cbx_param_cfgchain;

   localparam int CW = 20;
   localparam int NP = 4;
   localparam int MS = 10;
   localparam int TS = 4;
   localparam int SW = 4;
`ifdef CBX_PARAM_CFG_PARITY_EN
   localparam bit PAR = 1'b1;
   localparam int L   = 17;
   localparam int OFF = 1;
`else
   localparam bit PAR = 1'b0;
   localparam int L   = 16;
   localparam int OFF = 0;
`endif

   logic          prog_clk;
   logic          prog_reset;
   logic          ccff_en;
   logic          ccff_head;
   logic [CW-1:0] chanx_left_in;
   logic [CW-1:0] chanx_right_in;
   logic [CW-1:0] chanx_left_out;
   logic [CW-1:0] chanx_right_out;
   logic [NP-1:0] top_grid_pin;
   logic          ccff_tail;
   logic          cfg_done;
   logic          cfg_err;

   cbx_param_cfgchain #(
      .CHAN_WIDTH   (CW),
      .NUM_IPIN     (NP),
      .MUX_SIZE     (MS),
      .TRACK_STRIDE (TS)
   ) dut (
      .prog_clk        (prog_clk),
      .prog_reset      (prog_reset),
      .ccff_en         (ccff_en),
      .ccff_head       (ccff_head),
      .chanx_left_in   (chanx_left_in),
      .chanx_right_in  (chanx_right_in),
      .chanx_left_out  (chanx_left_out),
      .chanx_right_out (chanx_right_out),
      .top_grid_pin    (top_grid_pin),
      .ccff_tail       (ccff_tail),
      .cfg_done        (cfg_done),
      .cfg_err         (cfg_err)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: hist[k] is the bit shifted in k enabled edges ago (the chain content).
   bit hist[$];
   int m_cnt;
   bit m_done;
   bit m_prev_en;

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < L; i++) hist.push_back(1'b0);
      m_cnt     = 0;
      m_done    = 1'b0;
      m_prev_en = 1'b0;
   endtask

   task automatic model_edge(input logic en, input logic head);
      if (en) begin
         hist.push_front(head);
         void'(hist.pop_back());
         if (m_done && !m_prev_en) begin
            m_done = 1'b0;
            m_cnt  = 1;
         end else if (!m_done) begin
            m_cnt++;
            if (m_cnt == L) m_done = 1'b1;
         end
      end
      m_prev_en = en;
   endtask

   function automatic bit m_err();
      bit r = 1'b0;
      foreach (hist[i]) r ^= hist[i];
      return PAR && m_done && r;
   endfunction

   function automatic logic [NP-1:0] m_pins();
      logic [NP-1:0] r = '0;
      if (!m_done || m_err()) return '0;
      for (int p = 0; p < NP; p++) begin
         int sel = 0;
         for (int b = 0; b < SW; b++) sel += int'(hist[OFF + p*SW + b]) << b;
         if (sel < MS) begin
            int t = (p + (sel / 2) * TS) % CW;
            r[p] = (sel % 2 == 1) ? chanx_right_in[t] : chanx_left_in[t];
         end
      end
      return r;
   endfunction

   task automatic check_all(input string name);
      check({name, "/done"},     32'(cfg_done),        32'(m_done));
      check({name, "/err"},      32'(cfg_err),         32'(m_err()));
      check({name, "/tail"},     32'(ccff_tail),       32'(hist[L-1]));
      check({name, "/pins"},     32'(top_grid_pin),    32'(m_pins()));
      check({name, "/left_out"}, 32'(chanx_left_out),  32'(chanx_right_in));
      check({name, "/right_out"},32'(chanx_right_out), 32'(chanx_left_in));
   endtask

   task automatic tick();
      @(posedge prog_clk);
      if (!prog_reset) model_edge(ccff_en, ccff_head);
      #1;
   endtask

   task automatic do_reset();
      prog_reset = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      tick();
      prog_reset = 1'b0;
   endtask

   task automatic load_word(input logic [L-1:0] w, input string name);
      for (int i = L - 1; i >= 0; i--) begin
         ccff_en   = 1'b1;
         ccff_head = w[i];
         tick();
         check_all(name);
      end
   endtask

   function automatic logic [L-1:0] make_word(input int s0, input int s1, input int s2, input int s3);
      logic [L-1:0] w = '0;
      w[OFF + 0*SW +: SW] = SW'(s0);
      w[OFF + 1*SW +: SW] = SW'(s1);
      w[OFF + 2*SW +: SW] = SW'(s2);
      w[OFF + 3*SW +: SW] = SW'(s3);
      if (PAR) w[0] = ^w;
      return w;
   endfunction

   typedef struct {
      logic [CW-1:0] left;
      logic [CW-1:0] right;
      logic [NP-1:0] pins;
   } vec_t;

   vec_t vecs[7];
   logic [L-1:0] word;

   initial begin
      // Selects {0,5,12,9}: pin0=left[0], pin1=right[9], pin2=0, pin3=right[19].
      vecs[0] = '{20'h00001, 20'h00000, 4'b0001};
      vecs[1] = '{20'h00000, 20'h00200, 4'b0010};
      vecs[2] = '{20'h00000, 20'h00000, 4'b0000};
      vecs[3] = '{20'h00000, 20'h80000, 4'b1000};
      vecs[4] = '{20'hFFFFF, 20'hFFFFF, 4'b1011};
      vecs[5] = '{20'hFFFFE, 20'h7FDFF, 4'b0000};
      vecs[6] = '{20'h00001, 20'h80200, 4'b1011};

      prog_reset     = 1'b1;
      ccff_en        = 1'b0;
      ccff_head      = 1'b0;
      chanx_left_in  = 20'hA5A5A;
      chanx_right_in = 20'h0F0F0;
      model_reset();
      #3;
      check("pt_rst/right_out", 32'(chanx_right_out), 32'h000A5A5A);
      check("pt_rst/left_out",  32'(chanx_left_out),  32'h0000F0F0);
      check("rst/done", 32'(cfg_done), 32'd0);
      check("rst/tail", 32'(ccff_tail), 32'd0);
      check("rst/pins", 32'(top_grid_pin), 32'd0);
      check("rst/err",  32'(cfg_err), 32'd0);
      tick();
      tick();
      prog_reset = 1'b0;
      #1;
      check("pt_run/right_out", 32'(chanx_right_out), 32'h000A5A5A);
      check("pt_run/left_out",  32'(chanx_left_out),  32'h0000F0F0);

      // All-zero configuration: pin0 follows left[0] once done.
      chanx_left_in = 20'h00001;
      for (int i = 0; i < L; i++) begin
         ccff_en   = 1'b1;
         ccff_head = 1'b0;
         tick();
         if (i == L - 2) begin
            check("zero_cfg/done_early", 32'(cfg_done), 32'd0);
            check("zero_cfg/pin0_early", 32'(top_grid_pin[0]), 32'd0);
         end
         check_all("zero_cfg");
      end
      check("zero_cfg/done", 32'(cfg_done), 32'd1);
      check("zero_cfg/pin0", 32'(top_grid_pin[0]), 32'd1);

      // Reconfigure after a low cycle, then sweep the mapping table.
      ccff_en = 1'b0;
      tick();
      word = make_word(0, 5, 12, 9);
      load_word(word, "map_load");
      ccff_en = 1'b0;
      check("map_load/done", 32'(cfg_done), 32'd1);
      for (int i = 0; i < 7; i++) begin
         chanx_left_in  = vecs[i].left;
         chanx_right_in = vecs[i].right;
         #1;
         check($sformatf("map_vec%0d", i), 32'(top_grid_pin), 32'(vecs[i].pins));
         check_all("map_model");
      end

      // Chain latency and continuous pass-through shifting in DONE.
      do_reset();
      for (int i = 0; i < L; i++) begin
         ccff_en   = 1'b1;
         ccff_head = (i == 0);
         tick();
         if (i == L - 2) check("lat/tail_early", 32'(ccff_tail), 32'd0);
         check_all("lat");
      end
      check("lat/tail", 32'(ccff_tail), 32'd1);
      check("lat/done", 32'(cfg_done), 32'd1);
      for (int i = 0; i < 5; i++) begin
         ccff_head = 1'b0;
         tick();
         check("lat/done_hold", 32'(cfg_done), 32'd1);
         check_all("lat_hold");
      end

      // Pause mid-load: 7 shifts, 5 idle, remaining shifts.
      ccff_en = 1'b0;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         ccff_en = 1'b1; ccff_head = 1'($urandom); tick(); check_all("pause_a");
      end
      for (int i = 0; i < 5; i++) begin
         ccff_en = 1'b0; tick();
         check("pause/done_idle", 32'(cfg_done), 32'd0);
      end
      for (int i = 7; i < L; i++) begin
         ccff_en = 1'b1; ccff_head = 1'($urandom); tick();
         if (i == L - 2) check("pause/done_early", 32'(cfg_done), 32'd0);
         check_all("pause_b");
      end
      check("pause/done", 32'(cfg_done), 32'd1);

      // Reset mid-shift after extra pass-through shifts of ones.
      chanx_left_in  = '1;
      chanx_right_in = '1;
      for (int i = 0; i < 10; i++) begin
         ccff_head = 1'b1; tick(); check_all("rst_mid_pre");
      end
      prog_reset = 1'b1;
      #1;
      check("rst_mid/done", 32'(cfg_done), 32'd0);
      check("rst_mid/tail", 32'(ccff_tail), 32'd0);
      check("rst_mid/pins", 32'(top_grid_pin), 32'd0);
      check("rst_mid/err",  32'(cfg_err), 32'd0);
      model_reset();
      tick();
      prog_reset = 1'b0;
      for (int i = 0; i < L; i++) begin
         ccff_head = 1'b0; tick();
         if (i == L - 2) check("rst_mid/idle_restart", 32'(cfg_done), 32'd0);
         check_all("rst_mid_post");
      end

      // Parity: clean word, then the same word with one bit flipped.
      ccff_en = 1'b0;
      do_reset();
      load_word(make_word(0, 5, 3, 9), "par_ok");
      check("par_ok/err", 32'(cfg_err), 32'd0);
      ccff_en = 1'b0;
      tick();
      word = make_word(0, 5, 3, 9);
      word[OFF + 6] = ~word[OFF + 6];
      load_word(word, "par_bad");
      check("par_bad/err", 32'(cfg_err), 32'(PAR));
      if (PAR) check("par_bad/pins", 32'(top_grid_pin), 32'd0);

      // Random stimulus with occasional asynchronous resets.
      ccff_en = 1'b0;
      for (int i = 0; i < 400; i++) begin
         chanx_left_in  = CW'($urandom);
         chanx_right_in = CW'($urandom);
         ccff_en        = ($urandom_range(0, 9) < 9);
         ccff_head      = 1'($urandom);
         if ($urandom_range(0, 59) == 0) do_reset();
         else begin
            tick();
            check_all("rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
